multi_wave_gen: RTL and testbench
=================================

Name: multi_wave_gen

Overview:
- Parametrised tone generator and the successor to the fixed 16-bit square-wave source.
- Produces square, variable-duty pulse, sawtooth or triangle samples from a free-running phase counter.
- Samples are emitted on an external codec frame strobe with a one-cycle write strobe.
- Sits between the note/period control logic and the audio sample FIFO/codec interface.

Parameters:
SAMPLE_W, 16, sample/volume/slope width
PERIOD_W, 21, half-period counter width

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  generator run; low forces idle
sample_tick  in  1  one-cycle codec frame strobe
mode  in  2  0 square, 1 pulse, 2 sawtooth, 3 triangle
half_period  in  PERIOD_W  half period in clocks minus 1
duty  in  PERIOD_W+1  pulse high-time in clocks (mode 1)
slope  in  SAMPLE_W  ramp increment per clock (modes 2/3)
volume  in  SAMPLE_W  peak amplitude (unsigned)
sample  out  SAMPLE_W  registered output sample
wr  out  1  one-cycle strobe, sample valid
sync  out  1  one-cycle pulse at each full-period start

Behaviour:
- Reset (async, active-high): counter=0, h=0, ramp=0, active_mode=0, sample=0, wr=0, sync=0.
- Reset mid-operation clears all state immediately, with no partial sample written.
- enable low (synchronous): counter=0, h=0, ramp=0, sample=0, wr=0, sync=0; active_mode<=mode every cycle.
- Phase counter, enable high:
  - If counter>=half_period then counter<=0, h<=~h (half wrap); else counter+1.
  - Half wrap with h=1 is a full wrap: sync<=1 next cycle, active_mode<=mode, ramp<=0.
  - Otherwise sync<=0.
  - half_period=0: half wrap every cycle, h toggles every clock, sync every 2nd clock.
- Mode changes take effect only at a full wrap or while disabled. No mid-period glitch.
- Position pos = h ? counter+half_period+1 : counter, width PERIOD_W+1.
- Ramp register, SAMPLE_W bits, computed at SAMPLE_W+1 bits, updated every clock when not full-wrapping:
  - mode 2, or mode 3 with h=0: ramp<=min(ramp+slope, volume).
  - mode 3 with h=1: ramp<=max(ramp-slope, 0).
  - modes 0/1: ramp held at 0.
- Wave value w (combinational):
  - mode 0: h ? volume : 0.
  - mode 1: (pos<duty) ? volume : 0. duty=0 gives constant 0; duty>=2*(half_period+1) gives constant volume.
  - modes 2/3: min(ramp, volume). A volume drop takes effect immediately.
- Output, enable high:
  - On a clock edge with sample_tick=1: sample<=w, wr<=1.
  - Otherwise wr<=0 and sample holds.
  - wr and the new sample are visible in the same cycle.
  - sample_tick high for N cycles gives N samples and wr high for N cycles.
- enable rising: counting starts from counter=0, h=0 on the first enabled edge; the first sync comes after one full period.
- Simultaneous sample_tick and full wrap: sample takes w from pre-wrap state (old mode, old ramp).

Test Plan:
- Square: half_period=3, volume=0x1000, mode=0, sample_tick=1 continuously -> sample repeats 0 x4 then 0x1000 x4 (transitions 1 cycle after each half wrap); wr constantly 1; sync every 8 cycles.
- Pulse: half_period=3, duty=2, then duty=0, then duty=9, volume=0x0800 -> 0x0800 for 2 of 8 cycles; then constant 0; then constant 0x0800.
- Sawtooth/triangle: half_period=3, slope=0x100, volume=0x1000.
  - mode 2 -> samples 0,0x100,...,0x700 then back to 0.
  - mode 3 -> 0x100..0x400 rising, then down to 0x000 each period.
  - slope=0x800 with volume=0x1000 -> saturates at 0x1000.
- Mode change mid-period: switch 0->2 at counter=1, h=1 -> square continues until the full wrap; saw starts at 0 with sync=1.
- Sparse ticks and enable: sample_tick every 5th cycle -> wr only on those cycles and sample holds between; drop enable mid-period -> next cycle sample=0, wr=0, counter=0; re-enable -> sync 8 cycles later.
- Reset: assert reset asynchronously mid-ramp (ramp=0x300) -> all outputs 0 immediately; after release with enable=1 -> sequence restarts from counter=0, h=0.

Source files
------------

// File: rtl/multi_wave_gen.sv
// multi_wave_gen: square / pulse / sawtooth / triangle tone generator.
// A free-running half-period counter plus half flag (h) forms the phase;
// samples are registered on the codec frame strobe (sample_tick) with a
// one-cycle write strobe (wr). sync pulses once per full period.
// Ports: clock, reset (async high), enable, sample_tick, mode[1:0],
//        half_period, duty, slope, volume -> sample, wr, sync.
module multi_wave_gen #(
    parameter int SAMPLE_W = 16,
    parameter int PERIOD_W = 21
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                sample_tick,
    input  logic [1:0]          mode,
    input  logic [PERIOD_W-1:0] half_period,
    input  logic [PERIOD_W:0]   duty,
    input  logic [SAMPLE_W-1:0] slope,
    input  logic [SAMPLE_W-1:0] volume,
    output logic [SAMPLE_W-1:0] sample,
    output logic                wr,
    output logic                sync
);

    typedef enum logic [1:0] {
        M_SQUARE = 2'd0,
        M_PULSE  = 2'd1,
        M_SAW    = 2'd2,
        M_TRI    = 2'd3
    } mode_t;

    localparam logic [PERIOD_W-1:0] CNT_ONE = PERIOD_W'(1);
    localparam logic [PERIOD_W:0]   POS_ONE = (PERIOD_W + 1)'(1);

    logic [PERIOD_W-1:0] counter;
    logic                h;
    logic [SAMPLE_W-1:0] ramp;
    mode_t               active_mode;

    logic                half_wrap;
    logic                full_wrap;
    logic [PERIOD_W:0]   pos;
    logic [SAMPLE_W:0]   ramp_sum;
    logic [SAMPLE_W:0]   ramp_diff;
    logic [SAMPLE_W-1:0] ramp_up;
    logic [SAMPLE_W-1:0] ramp_down;
    logic [SAMPLE_W-1:0] ramp_clip;
    logic [SAMPLE_W-1:0] w;

    assign half_wrap = (counter >= half_period);
    assign full_wrap = half_wrap && h;

    // Position within the full period; second half is offset by half_period+1.
    assign pos = h ? ({1'b0, counter} + {1'b0, half_period} + POS_ONE)
                   : {1'b0, counter};

    // One extra bit so ramp+slope overflow and ramp-slope underflow are seen.
    assign ramp_sum  = {1'b0, ramp} + {1'b0, slope};
    assign ramp_diff = {1'b0, ramp} - {1'b0, slope};
    assign ramp_up   = (ramp_sum > {1'b0, volume}) ? volume
                                                   : ramp_sum[SAMPLE_W-1:0];
    assign ramp_down = ramp_diff[SAMPLE_W] ? '0 : ramp_diff[SAMPLE_W-1:0];
    // Clip against the live volume so a volume drop is heard at once.
    assign ramp_clip = (ramp > volume) ? volume : ramp;

    always_comb begin
        w = '0;
        unique case (active_mode)
            M_SQUARE: w = h ? volume : '0;
            M_PULSE:  w = (pos < duty) ? volume : '0;
            M_SAW,
            M_TRI:    w = ramp_clip;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            counter     <= '0;
            h           <= 1'b0;
            ramp        <= '0;
            active_mode <= M_SQUARE;
            sample      <= '0;
            wr          <= 1'b0;
            sync        <= 1'b0;
        end else if (!enable) begin
            counter     <= '0;
            h           <= 1'b0;
            ramp        <= '0;
            active_mode <= mode_t'(mode);
            sample      <= '0;
            wr          <= 1'b0;
            sync        <= 1'b0;
        end else begin
            if (half_wrap) begin
                counter <= '0;
                h       <= ~h;
            end else begin
                counter <= counter + CNT_ONE;
            end

            sync <= full_wrap;

            // Mode is only latched at a period boundary to avoid glitches.
            if (full_wrap) begin
                active_mode <= mode_t'(mode);
                ramp        <= '0;
            end else begin
                unique case (active_mode)
                    M_SQUARE,
                    M_PULSE:  ramp <= '0;
                    M_SAW:    ramp <= ramp_up;
                    M_TRI:    ramp <= h ? ramp_down : ramp_up;
                endcase
            end

            // Output uses pre-wrap state (old mode, old ramp).
            if (sample_tick) begin
                sample <= w;
                wr     <= 1'b1;
            end else begin
                wr     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multi_wave_gen.sv
// tb_multi_wave_gen: scoreboard bench for multi_wave_gen.
// Stimulus pushes hand-computed samples; a monitor pops them on wr.
module tb_multi_wave_gen;

    localparam int SW = 16;
    localparam int PW = 21;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic          sample_tick;
    logic [1:0]    mode;
    logic [PW-1:0] half_period;
    logic [PW:0]   duty;
    logic [SW-1:0] slope;
    logic [SW-1:0] volume;
    logic [SW-1:0] sample;
    logic          wr;
    logic          sync;

    int checks   = 0;
    int failures = 0;

    logic [SW-1:0] expq[$];
    logic [SW-1:0] vec[$];
    logic [SW-1:0] mon_exp;

    multi_wave_gen #(.SAMPLE_W(SW), .PERIOD_W(PW)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .sample_tick (sample_tick),
        .mode        (mode),
        .half_period (half_period),
        .duty        (duty),
        .slope       (slope),
        .volume      (volume),
        .sample      (sample),
        .wr          (wr),
        .sync        (sync)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every wr must match the oldest expected sample.
    always @(posedge clock) begin
        #1;
        if (wr === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_wr actual=%0h required=none",
                         sample);
            end else begin
                mon_exp = expq.pop_front();
                check("sample", {16'h0, sample}, {16'h0, mon_exp});
            end
        end
    end

    task automatic rep(input logic [SW-1:0] v, input int n);
        for (int i = 0; i < n; i++) vec.push_back(v);
    endtask

    // Called at a negedge: one disabled edge clears phase, latches mode.
    task automatic restart();
        enable      = 1'b0;
        sample_tick = 1'b0;
        @(negedge clock);
        check("idle_wr", {31'h0, wr}, 32'h0);
        check("idle_sample", {16'h0, sample}, 32'h0);
        enable = 1'b1;
    endtask

    // n cycles; tick when i%every==0 (every=0: no ticks); sync expected
    // at i%per==per-1; optional mode switch before edge sw_at.
    task automatic run(input int n, input int every, input int per,
                       input int sw_at, input logic [1:0] sw_mode);
        logic [SW-1:0] held;
        logic          tk;
        held = sample;
        for (int i = 0; i < n; i++) begin
            if (i == sw_at) mode = sw_mode;
            tk = (every > 0) && (i % every == 0);
            sample_tick = tk;
            if (tk) begin
                held = vec.pop_front();
                expq.push_back(held);
            end
            @(negedge clock);
            check("sync", {31'h0, sync},
                  {31'h0, (i % per) == (per - 1)});
            if (!tk) begin
                check("no_tick_wr", {31'h0, wr}, 32'h0);
                check("hold", {16'h0, sample}, {16'h0, held});
            end
        end
        sample_tick = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        sample_tick = 1'b0;
        mode        = 2'd0;
        half_period = 21'd3;
        duty        = '0;
        slope       = '0;
        volume      = '0;
        repeat (2) @(negedge clock);
        check("rst_sample", {16'h0, sample}, 32'h0);
        check("rst_wr", {31'h0, wr}, 32'h0);
        check("rst_sync", {31'h0, sync}, 32'h0);
        reset = 1'b0;

        // Square, half_period=3
        mode = 2'd0; volume = 16'h1000;
        restart();
        vec.delete(); rep(16'h0, 4); rep(16'h1000, 4);
        rep(16'h0, 4); rep(16'h1000, 4);
        run(16, 1, 8, -1, 2'd0);

        // Square, half_period=0: toggles every clock
        half_period = 21'd0; volume = 16'h1234;
        restart();
        vec.delete();
        for (int i = 0; i < 3; i++) begin
            vec.push_back(16'h0); vec.push_back(16'h1234);
        end
        run(6, 1, 2, -1, 2'd0);
        half_period = 21'd3;

        // Pulse duty 2 / 0 / 8 / 9
        mode = 2'd1; volume = 16'h0800; duty = 22'd2;
        restart();
        vec.delete(); rep(16'h0800, 2); rep(16'h0, 6);
        run(8, 1, 8, -1, 2'd1);
        duty = 22'd0;
        restart();
        vec.delete(); rep(16'h0, 8);
        run(8, 1, 8, -1, 2'd1);
        duty = 22'd8;
        restart();
        vec.delete(); rep(16'h0800, 8);
        run(8, 1, 8, -1, 2'd1);
        duty = 22'd9;
        restart();
        vec.delete(); rep(16'h0800, 8);
        run(8, 1, 8, -1, 2'd1);

        // Sawtooth
        mode = 2'd2; slope = 16'h0100; volume = 16'h1000;
        restart();
        vec.delete();
        for (int i = 0; i < 8; i++) vec.push_back(16'(i * 256));
        vec.push_back(16'h0);
        run(9, 1, 8, -1, 2'd2);

        // Triangle
        mode = 2'd3;
        restart();
        vec = '{16'h000, 16'h100, 16'h200, 16'h300, 16'h400,
                16'h300, 16'h200, 16'h100, 16'h000};
        run(9, 1, 8, -1, 2'd3);

        // Saw saturating at volume
        mode = 2'd2; slope = 16'h0800;
        restart();
        vec.delete(); vec.push_back(16'h0); vec.push_back(16'h0800);
        rep(16'h1000, 6);
        run(8, 1, 8, -1, 2'd2);

        // Saw with 16-bit overflow of ramp+slope
        slope = 16'hF000; volume = 16'hFFFF;
        restart();
        vec.delete(); vec.push_back(16'h0); vec.push_back(16'hF000);
        rep(16'hFFFF, 6);
        run(8, 1, 8, -1, 2'd2);

        // Triangle clamping at volume and at zero
        mode = 2'd3; slope = 16'h0800; volume = 16'h1000;
        restart();
        vec = '{16'h0000, 16'h0800, 16'h1000, 16'h1000,
                16'h1000, 16'h0800, 16'h0000, 16'h0000};
        run(8, 1, 8, -1, 2'd3);

        // Mode change 0 -> 2 at counter=1, h=1
        mode = 2'd0; slope = 16'h0100; volume = 16'h1000;
        restart();
        vec.delete(); rep(16'h0, 4); rep(16'h1000, 4);
        for (int i = 0; i < 8; i++) vec.push_back(16'(i * 256));
        run(16, 1, 8, 5, 2'd2);

        // Sparse ticks, then drop enable mid-period
        mode = 2'd0;
        restart();
        vec = '{16'h0000, 16'h1000, 16'h0000};
        run(12, 5, 8, -1, 2'd0);
        enable = 1'b0;
        @(negedge clock);
        check("dis_sample", {16'h0, sample}, 32'h0);
        check("dis_wr", {31'h0, wr}, 32'h0);
        check("dis_sync", {31'h0, sync}, 32'h0);
        enable = 1'b1;
        run(8, 0, 8, -1, 2'd0);

        // Async reset mid-ramp; active mode returns to square
        mode = 2'd2;
        restart();
        vec = '{16'h000, 16'h100, 16'h200};
        run(3, 1, 8, -1, 2'd2);
        #2 reset = 1'b1;
        #1;
        check("arst_sample", {16'h0, sample}, 32'h0);
        check("arst_wr", {31'h0, wr}, 32'h0);
        check("arst_sync", {31'h0, sync}, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        vec.delete(); rep(16'h0, 4); rep(16'h1000, 4);
        for (int i = 0; i < 8; i++) vec.push_back(16'(i * 256));
        run(16, 1, 8, -1, 2'd2);

        repeat (3) @(negedge clock);
        check("drain", expq.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
